// File: rtl/game_pkg.sv
// Shared stage-play constants: map geometry, arbiter FSM encoding and requester indices.
package game_pkg;

  localparam int ORIGIN_X = 60;
  localparam int ORIGIN_Y = 30;
  localparam int CELL     = 5;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_BOSS   = 1;
  localparam int REQ_OBJ    = 2;

endpackage

// File: rtl/map_port_arbiter_if.sv
// Requester-side bus of the map port arbiter: level requests with packed pixel
// coordinates in, one-hot grant / response pulses and the shared blocked flag out.
interface map_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int COORD_W = 9
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic                       rsp_blocked;

  modport master (output req, req_x, req_y, input gnt, rsp_valid, rsp_blocked);
  modport slave  (input req, req_x, req_y, output gnt, rsp_valid, rsp_blocked);
endinterface

// File: rtl/pixel_to_cell.sv
// Combinational pixel -> map cell converter. With MAP_BOUNDS_CHECK_EN defined the
// in_map flag reports whether the pixel lies inside the map; otherwise it is always 1.
module pixel_to_cell
  import game_pkg::*;
#(
  parameter int COORD_W = 9
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [5:0]         row,
  output logic [5:0]         col,
  output logic               in_map
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  // Unsigned subtraction: pixels left of / above the origin wrap to large values.
  assign dx = x - COORD_W'(ORIGIN_X);
  assign dy = y - COORD_W'(ORIGIN_Y);

`ifdef MAP_BOUNDS_CHECK_EN
  logic [COORD_W-1:0] col_full;
  logic [COORD_W-1:0] row_full;

  assign col_full = dx / COORD_W'(CELL);
  assign row_full = dy / COORD_W'(CELL);
  assign col      = col_full[5:0];
  assign row      = row_full[5:0];
  assign in_map   = (x >= COORD_W'(ORIGIN_X)) && (y >= COORD_W'(ORIGIN_Y)) &&
                    (col_full < COORD_W'(MAP_COLS)) && (row_full < COORD_W'(MAP_ROWS));
`else
  assign col    = 6'(dx / COORD_W'(CELL));
  assign row    = 6'(dy / COORD_W'(CELL));
  assign in_map = 1'b1;
`endif

endmodule

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing the collision map ROM read port between movers;
// one lookup (grant, ROM read, one-cycle response) per ROM_LAT+2 cycles.
module map_port_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int COORD_W = 9,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  map_port_arbiter_if.slave  bus,
  output logic               map_rd,
  output logic [5:0]         map_row,
  output logic [5:0]         map_col,
  input  logic               map_bit,
  output logic               busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  arb_state_e         state_reg;
  logic [IDX_W-1:0]   last_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   lat_cnt_reg;
  logic               in_map_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic               rsp_blocked_reg;
  logic               map_rd_reg;
  logic [5:0]         row_reg;
  logic [5:0]         col_reg;
  logic               busy_reg;

  logic [COORD_W-1:0] x_arr [NUM_REQ];
  logic [COORD_W-1:0] y_arr [NUM_REQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;
  logic [5:0]         cell_row;
  logic [5:0]         cell_col;
  logic               cell_in_map;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign x_arr[gi] = bus.req_x[gi*COORD_W +: COORD_W];
      assign y_arr[gi] = bus.req_y[gi*COORD_W +: COORD_W];
    end
  endgenerate

  // Priority search starts just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_reg) + k) % NUM_REQ;
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  pixel_to_cell #(.COORD_W(COORD_W)) u_pixel_to_cell (
    .x      (x_arr[win_idx]),
    .y      (y_arr[win_idx]),
    .row    (cell_row),
    .col    (cell_col),
    .in_map (cell_in_map)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      last_reg        <= IDX_W'(NUM_REQ - 1);
      idx_reg         <= '0;
      lat_cnt_reg     <= '0;
      in_map_reg      <= 1'b0;
      gnt_reg         <= '0;
      rsp_valid_reg   <= '0;
      rsp_blocked_reg <= 1'b0;
      map_rd_reg      <= 1'b0;
      row_reg         <= '0;
      col_reg         <= '0;
      busy_reg        <= 1'b0;
    end else begin
      gnt_reg       <= '0;
      map_rd_reg    <= 1'b0;
      rsp_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg   <= LOOKUP;
            busy_reg    <= 1'b1;
            last_reg    <= win_idx;
            idx_reg     <= win_idx;
            lat_cnt_reg <= '0;
            gnt_reg     <= NUM_REQ'(1) << win_idx;
            map_rd_reg  <= cell_in_map;
            in_map_reg  <= cell_in_map;
            row_reg     <= cell_row;
            col_reg     <= cell_col;
          end
        end
        LOOKUP: begin
          if (lat_cnt_reg == CNT_W'(ROM_LAT - 1)) begin
            state_reg              <= RESP;
            rsp_valid_reg[idx_reg] <= 1'b1;
            // Out-of-map cells never touched the ROM and always read as wall.
            rsp_blocked_reg        <= in_map_reg ? map_bit : 1'b1;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_blocked = rsp_blocked_reg;
  assign map_rd          = map_rd_reg;
  assign map_row         = row_reg;
  assign map_col         = col_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench: one arbiter with ROM_LAT=1 and one with ROM_LAT=3, each behind a
// model ROM whose data is only correct in the cycle the arbiter should sample it.
module tb_map_port_arbiter;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  map_port_arbiter_if #(.NUM_REQ(3), .COORD_W(9)) bus1 ();
  map_port_arbiter_if #(.NUM_REQ(3), .COORD_W(9)) bus3 ();

  logic       map_rd1, map_bit1, busy1;
  logic       map_rd3, map_bit3, busy3;
  logic [5:0] row1, col1, row3, col3;
  logic [1:0] cnt3 = 2'd0;

  int n_checks = 0;
  int n_pass   = 0;

  map_port_arbiter #(.NUM_REQ(3), .COORD_W(9), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .map_rd(map_rd1),
    .map_row(row1), .map_col(col1), .map_bit(map_bit1), .busy(busy1)
  );

  map_port_arbiter #(.NUM_REQ(3), .COORD_W(9), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .map_rd(map_rd3),
    .map_row(row3), .map_col(col3), .map_bit(map_bit3), .busy(busy3)
  );

  // Model map: walls on the diagonal only.
  function automatic logic rom_bit(input logic [5:0] r, input logic [5:0] c);
    return r == c;
  endfunction

  // Data is inverted outside the cycle in which the arbiter is meant to sample it.
  assign map_bit1 = map_rd1 ? rom_bit(row1, col1) : ~rom_bit(row1, col1);
  always @(posedge clk) cnt3 <= map_rd3 ? 2'd1 : ((cnt3 != 2'd0) ? cnt3 + 2'd1 : 2'd0);
  assign map_bit3 = (cnt3 == 2'd2) ? rom_bit(row3, col3) : ~rom_bit(row3, col3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set1(input int i, input int x, input int y);
    bus1.req_x[i*9 +: 9] = 9'(x);
    bus1.req_y[i*9 +: 9] = 9'(y);
  endtask

  logic [2:0] exp_gnt;

  initial begin
    bus1.req = '0; bus1.req_x = '0; bus1.req_y = '0;
    bus3.req = '0; bus3.req_x = '0; bus3.req_y = '0;

    // Reset state
    tick(); tick();
    check("rst_gnt", bus1.gnt, 0);
    check("rst_rsp_valid", bus1.rsp_valid, 0);
    check("rst_blocked", bus1.rsp_blocked, 0);
    check("rst_map_rd", map_rd1, 0);
    check("rst_row", row1, 0);
    check("rst_col", col1, 0);
    check("rst_busy", busy1, 0);
    rst = 1'b1;
    tick();
    check("idle_map_rd", map_rd1, 0);
    check("idle_busy", busy1, 0);
    $display("txn reset: outputs quiet");

    // Basic lookup: player at (65,35) -> cell (1,1), a wall
    set1(REQ_PLAYER, 65, 35);
    bus1.req = 3'b001;
    tick();
    check("basic_gnt", bus1.gnt, 3'b001);
    check("basic_map_rd", map_rd1, 1);
    check("basic_row", row1, 1);
    check("basic_col", col1, 1);
    check("basic_busy", busy1, 1);
    tick();
    check("basic_gnt_drop", bus1.gnt, 0);
    check("basic_rsp_valid", bus1.rsp_valid, 3'b001);
    check("basic_blocked", bus1.rsp_blocked, 1);
    bus1.req = '0;
    tick();
    check("basic_rsp_clear", bus1.rsp_valid, 0);
    check("basic_blocked_hold", bus1.rsp_blocked, 1);
    check("basic_busy_end", busy1, 0);
    $display("txn basic: row=%0d col=%0d blocked=%0d", row1, col1, bus1.rsp_blocked);

    // Round-robin with all three requesting free cells
    rst = 1'b0; tick(); rst = 1'b1;
    set1(REQ_PLAYER, 65, 40);   // row 2, col 1
    set1(REQ_BOSS, 100, 35);    // row 1, col 8
    set1(REQ_OBJ, 70, 30);      // row 0, col 2
    bus1.req = 3'b111;
    exp_gnt = 3'b001;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rr_gnt", bus1.gnt, exp_gnt);
      check("rr_map_rd", map_rd1, 1);
      tick();
      check("rr_rsp_valid", bus1.rsp_valid, exp_gnt);
      check("rr_blocked", bus1.rsp_blocked, 0);
      tick();
      $display("txn rr: grant %b served", exp_gnt);
      exp_gnt = {exp_gnt[1:0], exp_gnt[2]};
    end
    bus1.req = '0;

    // Boss at (59,100): left of the origin, column wraps to 102 -> 38 after truncation
    set1(REQ_BOSS, 59, 100);
    bus1.req = 3'b010;
    tick();
    check("bnd_gnt", bus1.gnt, 3'b010);
`ifdef MAP_BOUNDS_CHECK_EN
    check("bnd_map_rd", map_rd1, 0);
`else
    check("bnd_map_rd", map_rd1, 1);
    check("bnd_row", row1, 14);
    check("bnd_col", col1, 38);
`endif
    tick();
    check("bnd_rsp_valid", bus1.rsp_valid, 3'b010);
    check("bnd_map_rd_low", map_rd1, 0);
`ifdef MAP_BOUNDS_CHECK_EN
    check("bnd_blocked", bus1.rsp_blocked, 1);
`else
    check("bnd_blocked", bus1.rsp_blocked, 0);
`endif
    bus1.req = '0;
    tick();
    $display("txn bounds: blocked=%0d", bus1.rsp_blocked);

    // Reset during LOOKUP: boss granted, then reset; player must win afterwards
    bus1.req = 3'b010;
    tick();
    check("mid_gnt", bus1.gnt, 3'b010);
    rst = 1'b0;
    bus1.req = 3'b111;
    tick();
    check("mid_gnt_zero", bus1.gnt, 0);
    check("mid_rsp_valid", bus1.rsp_valid, 0);
    check("mid_blocked", bus1.rsp_blocked, 0);
    check("mid_map_rd", map_rd1, 0);
    check("mid_row", row1, 0);
    check("mid_col", col1, 0);
    check("mid_busy", busy1, 0);
    rst = 1'b1;
    tick();
    check("post_rst_gnt", bus1.gnt, 3'b001);
    check("post_rst_no_rsp", bus1.rsp_valid, 0);
    tick();
    check("post_rst_rsp", bus1.rsp_valid, 3'b001);
    bus1.req = '0;
    tick();
    $display("txn reset_mid_lookup: player regranted");

    // ROM_LAT=3: object at (255,209) -> row 35, col 39 (free)
    bus3.req_x[2*9 +: 9] = 9'd255;
    bus3.req_y[2*9 +: 9] = 9'd209;
    bus3.req = 3'b100;
    tick();
    check("lat3_gnt", bus3.gnt, 3'b100);
    check("lat3_map_rd", map_rd3, 1);
    check("lat3_row", row3, 35);
    check("lat3_col", col3, 39);
    bus3.req_x[2*9 +: 9] = 9'd0;
    tick();
    check("lat3_gnt_drop", bus3.gnt, 0);
    check("lat3_map_rd_drop", map_rd3, 0);
    check("lat3_row_hold", row3, 35);
    check("lat3_col_hold", col3, 39);
    check("lat3_early_rsp1", bus3.rsp_valid, 0);
    tick();
    check("lat3_early_rsp2", bus3.rsp_valid, 0);
    tick();
    check("lat3_rsp_valid", bus3.rsp_valid, 3'b100);
    check("lat3_blocked", bus3.rsp_blocked, 0);
    bus3.req = '0;
    tick();
    check("lat3_rsp_clear", bus3.rsp_valid, 0);
    check("lat3_busy_end", busy3, 0);
    $display("txn lat3: row=%0d col=%0d blocked=%0d", row3, col3, bus3.rsp_blocked);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
